// File: rtl/pipe_addsub.sv
// Pipelined lookahead adder/subtractor: operands are split into STAGES chunks,
// one chunk is resolved per stage with the carry registered between stages.
module pipe_addsub #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cIn,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cOut,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned CW = WIDTH / STAGES;

  logic en;

  // Global advance: an empty or retiring output slot lets every stage shift.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Parallel-prefix chunk adder; returns {carry_out, sum}.
  function automatic logic [CW:0] cla(input logic [CW-1:0] x,
                                      input logic [CW-1:0] y,
                                      input logic          ci);
    logic [CW-1:0] g, p, gg, pp, c;
    g  = x & y;
    p  = x ^ y;
    gg = g;
    pp = p;
    for (int d = 1; d < int'(CW); d = d * 2) begin
      for (int i = int'(CW) - 1; i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    c[0] = ci;
    for (int i = 1; i < int'(CW); i++) begin
      c[i] = gg[i-1] | (pp[i-1] & ci);
    end
    return {gg[CW-1] | (pp[CW-1] & ci), p ^ c};
  endfunction

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int unsigned LO = k * CW;
    localparam int unsigned BW = WIDTH - LO;

    // acc holds resolved sum chunks below LO and untouched operand-A chunks above.
    logic [WIDTH-1:0] acc_in, acc_nx;
    logic [BW-1:0]    b_in;
    logic             c_in, v_in;
    logic [CW:0]      r;

    if (k == 0) begin : g_src
      assign acc_in = a;
      assign b_in   = sub ? ~b : b;
      assign c_in   = cIn ^ sub;
      assign v_in   = in_valid;
    end else begin : g_src
      assign acc_in = g_stage[k-1].g_reg.acc_q;
      assign b_in   = g_stage[k-1].g_reg.b_q;
      assign c_in   = g_stage[k-1].g_reg.c_q;
      assign v_in   = g_stage[k-1].g_reg.v_q;
    end

    assign r = cla(acc_in[LO +: CW], b_in[CW-1:0], c_in);

    always_comb begin
      acc_nx             = acc_in;
      acc_nx[LO +: CW]   = r[CW-1:0];
    end

    if (k < int'(STAGES) - 1) begin : g_reg
      logic [WIDTH-1:0] acc_q;
      logic [BW-CW-1:0] b_q;
      logic             c_q, v_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          acc_q <= '0;
          b_q   <= '0;
          c_q   <= 1'b0;
          v_q   <= 1'b0;
        end else if (en) begin
          acc_q <= acc_nx;
          b_q   <= b_in[BW-1:CW];
          c_q   <= r[CW];
          v_q   <= v_in;
        end
      end
    end else begin : g_out
      logic cmsb;

      // Carry into the MSB recovered from the MSB sum bit and its operands.
      assign cmsb = acc_in[WIDTH-1] ^ b_in[CW-1] ^ acc_nx[WIDTH-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          out_valid <= 1'b0;
          s         <= '0;
          cOut      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
          neg       <= 1'b0;
        end else if (en) begin
          out_valid <= v_in;
          s         <= acc_nx;
          cOut      <= r[CW];
          ovf       <= cmsb ^ r[CW];
          zero      <= (acc_nx == '0);
          neg       <= acc_nx[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub: three configurations (64/4, 32/8, 16/1)
// with hand-computed vectors on 64/4 and a stalled stream on each.
module tb_pipe_addsub;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  in_valid, out_ready, in_ready, out_valid, cout, ovf, zero, neg;
  logic        cin, sub;
  logic [63:0] a0, b0, s0;
  logic [31:0] a1, b1, s1;
  logic [15:0] a2, b2, s2;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] bp_a [8] = '{64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF,
                            64'h7FFFFFFFFFFFFFFF, 64'h0000000000000000,
                            64'h8000000000000000, 64'hDEADBEEFCAFEF00D,
                            64'h0000000000000005, 64'h0000FFFF0000FFFF};
  logic [63:0] bp_b [8] = '{64'hFEDCBA9876543210, 64'h0000000000000001,
                            64'h0000000000000001, 64'h0000000000000001,
                            64'h8000000000000000, 64'h123456789ABCDEF0,
                            64'h0000000000000007, 64'hFFFF0000FFFF0000};
  logic [7:0]  bp_c = 8'b1010_0010;
  logic [7:0]  bp_s = 8'b0101_1000;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(64), .STAGES(4)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a0), .b(b0), .cIn(cin), .sub(sub), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .s(s0), .cOut(cout[0]), .ovf(ovf[0]),
    .zero(zero[0]), .neg(neg[0]));

  pipe_addsub #(.WIDTH(32), .STAGES(8)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a1), .b(b1), .cIn(cin), .sub(sub), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .s(s1), .cOut(cout[1]), .ovf(ovf[1]),
    .zero(zero[1]), .neg(neg[1]));

  pipe_addsub #(.WIDTH(16), .STAGES(1)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a2), .b(b2), .cIn(cin), .sub(sub), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .s(s2), .cOut(cout[2]), .ovf(ovf[2]),
    .zero(zero[2]), .neg(neg[2]));

  task automatic set_ops(input logic [63:0] av, input logic [63:0] bv,
                         input logic ci, input logic sb);
    a0 = av;        b0 = bv;
    a1 = av[31:0];  b1 = bv[31:0];
    a2 = av[15:0];  b2 = bv[15:0];
    cin = ci;       sub = sb;
  endtask

  function automatic logic [63:0] get_s(input int d);
    case (d)
      0:       return s0;
      1:       return 64'(s1);
      default: return 64'(s2);
    endcase
  endfunction

  function automatic int get_width(input int d);
    case (d)
      0:       return 64;
      1:       return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int get_stages(input int d);
    case (d)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  // Reference: plain wide addition, overflow from operand/result sign bits.
  function automatic void model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                input logic ci, input logic sb,
                                output logic [63:0] rs, output logic [3:0] rf);
    logic [63:0] m, am, ebm;
    logic [64:0] sum;
    logic        c, o, z, n;
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am  = av & m;
    ebm = (sb ? ~bv : bv) & m;
    sum = {1'b0, am} + {1'b0, ebm} + 65'(ci ^ sb);
    rs  = sum[63:0] & m;
    c   = sum[w];
    o   = (am[w-1] == ebm[w-1]) && (rs[w-1] != am[w-1]);
    z   = (rs == 64'd0);
    n   = rs[w-1];
    rf  = {c, o, z, n};
  endfunction

  // Presents one operand set to the 64/4 unit and counts edges until out_valid.
  task automatic send0(input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, input logic sb, output int lat);
    @(negedge clk);
    set_ops(av, bv, ci, sb);
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid[0] = 1'b0;
    end while (!out_valid[0] && lat < 20);
    if (!out_valid[0]) lat = -1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 3'b000;
    out_ready = 3'b111;
    set_ops(64'd0, 64'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({out_valid[d], cout[d], ovf[d], zero[d], neg[d]} !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset_flags dut%0d: got %b want 00000", d,
                 {out_valid[d], cout[d], ovf[d], zero[d], neg[d]});
      end
      n_cmp++;
      if (get_s(d) !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_s dut%0d: got %h want 0", d, get_s(d));
      end
      n_cmp++;
      if (in_ready[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_in_ready dut%0d: got %b want 1", d, in_ready[d]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_simple_add();
    int lat;
    send0(64'd1, 64'd1, 1'b0, 1'b0, lat);
    n_cmp++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL add_latency: got %0d want 4", lat);
    end
    n_cmp++;
    if (s0 !== 64'd2) begin
      n_fail++;
      $display("FAIL add_s: got %h want 2", s0);
    end
    n_cmp++;
    if ({cout[0], ovf[0], zero[0], neg[0]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL add_flags: got %b want 0000", {cout[0], ovf[0], zero[0], neg[0]});
    end
  endtask

  task automatic test_carry_ripple();
    int lat;
    send0(64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0, lat);
    n_cmp++;
    if (s0 !== 64'd0) begin
      n_fail++;
      $display("FAIL ripple_s: got %h want 0", s0);
    end
    n_cmp++;
    if ({cout[0], ovf[0], zero[0], neg[0]} !== 4'b1010) begin
      n_fail++;
      $display("FAIL ripple_flags: got %b want 1010", {cout[0], ovf[0], zero[0], neg[0]});
    end
  endtask

  task automatic test_overflow();
    int lat;
    send0(64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0, lat);
    n_cmp++;
    if (s0 !== 64'h8000000000000000) begin
      n_fail++;
      $display("FAIL ovf_s: got %h want 8000000000000000", s0);
    end
    n_cmp++;
    if ({cout[0], ovf[0], zero[0], neg[0]} !== 4'b0101) begin
      n_fail++;
      $display("FAIL ovf_flags: got %b want 0101", {cout[0], ovf[0], zero[0], neg[0]});
    end
  endtask

  task automatic test_subtract();
    logic [63:0] va [3] = '{64'd5, 64'hCCCCCCCCCCCCCCCC, 64'd5};
    logic [63:0] vb [3] = '{64'd7, 64'hCCCCCCCCCCCCCCCC, 64'd2};
    logic [63:0] es [3] = '{64'hFFFFFFFFFFFFFFFE, 64'd0, 64'd2};
    logic [3:0]  ef [3] = '{4'b0001, 4'b1010, 4'b1000};
    logic [2:0]  vc = 3'b100;
    int lat;
    for (int i = 0; i < 3; i++) begin
      send0(va[i], vb[i], vc[i], 1'b1, lat);
      n_cmp++;
      if (s0 !== es[i]) begin
        n_fail++;
        $display("FAIL sub%0d_s: got %h want %h", i, s0, es[i]);
      end
      n_cmp++;
      if ({cout[0], ovf[0], zero[0], neg[0]} !== ef[i]) begin
        n_fail++;
        $display("FAIL sub%0d_flags: got %b want %b", i,
                 {cout[0], ovf[0], zero[0], neg[0]}, ef[i]);
      end
    end
  endtask

  task automatic test_backpressure(input int d);
    logic [63:0] es [8];
    logic [3:0]  ef [8];
    int w, st, idx, ret, cyc, lo, extra;
    w  = get_width(d);
    st = get_stages(d);
    lo = st + 2;
    for (int i = 0; i < 8; i++) model(w, bp_a[i], bp_b[i], bp_c[i], bp_s[i], es[i], ef[i]);
    idx = 0; ret = 0; cyc = 0;
    out_ready = 3'b111;
    in_valid  = 3'b000;
    while (ret < 8 && cyc < 100) begin
      @(negedge clk);
      out_ready[d] = !(cyc >= lo && cyc < lo + 3);
      if (idx < 8) begin
        set_ops(bp_a[idx], bp_b[idx], bp_c[idx], bp_s[idx]);
        in_valid[d] = 1'b1;
      end else begin
        in_valid[d] = 1'b0;
      end
      #1;
      if (out_valid[d]) begin
        n_cmp++;
        if (get_s(d) !== es[ret]) begin
          n_fail++;
          $display("FAIL bp dut%0d res%0d s: got %h want %h", d, ret, get_s(d), es[ret]);
        end
        n_cmp++;
        if ({cout[d], ovf[d], zero[d], neg[d]} !== ef[ret]) begin
          n_fail++;
          $display("FAIL bp dut%0d res%0d flags: got %b want %b", d, ret,
                   {cout[d], ovf[d], zero[d], neg[d]}, ef[ret]);
        end
      end
      if (!out_ready[d]) begin
        n_cmp++;
        if ({out_valid[d], in_ready[d]} !== 2'b10) begin
          n_fail++;
          $display("FAIL bp dut%0d stall cyc%0d valid/ready: got %b want 10", d, cyc,
                   {out_valid[d], in_ready[d]});
        end
      end
      if (out_valid[d] && out_ready[d]) ret++;
      if (in_valid[d] && in_ready[d]) idx++;
      cyc++;
    end
    n_cmp++;
    if (ret != 8) begin
      n_fail++;
      $display("FAIL bp dut%0d count: got %0d results want 8", d, ret);
    end
    in_valid[d] = 1'b0;
    extra = 0;
    repeat (st + 2) begin
      @(negedge clk);
      if (out_valid[d]) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL bp dut%0d extra: got %0d extra results want 0", d, extra);
    end
  endtask

  task automatic test_reset_midstream();
    int lat, stale;
    out_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_ops(64'(100 + i), 64'd200, 1'b0, 1'b0);
      in_valid[0] = 1'b1;
    end
    @(negedge clk);
    set_ops(64'd9, 64'd9, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    in_valid[0] = 1'b0;
    n_cmp++;
    if ({out_valid[0], in_ready[0], cout[0], ovf[0], zero[0], neg[0]} !== 6'b010000) begin
      n_fail++;
      $display("FAIL midrst_state: got %b want 010000",
               {out_valid[0], in_ready[0], cout[0], ovf[0], zero[0], neg[0]});
    end
    n_cmp++;
    if (s0 !== 64'd0) begin
      n_fail++;
      $display("FAIL midrst_s: got %h want 0", s0);
    end
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid[0]) stale++;
    end
    n_cmp++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL midrst_stale: got %0d stale results want 0", stale);
    end
    send0(64'd3, 64'd4, 1'b0, 1'b0, lat);
    n_cmp++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL midrst_latency: got %0d want 4", lat);
    end
    n_cmp++;
    if (s0 !== 64'd7) begin
      n_fail++;
      $display("FAIL midrst_s_after: got %h want 7", s0);
    end
  endtask

  initial begin
    test_reset();
    test_simple_add();
    test_carry_ripple();
    test_overflow();
    test_subtract();
    test_backpressure(0);
    test_backpressure(1);
    test_backpressure(2);
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
